// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive-side buffer.
//   UART_DATA_W   - receiver byte width
//   RXBUF_DEPTH   - default receive buffer depth (entries)
//   rxbuf_state_t - capture FSM states
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int RXBUF_DEPTH = 16;

  typedef enum logic {
    WAIT = 1'b0,
    ACK  = 1'b1
  } rxbuf_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO.
// The head entry is visible on rdata whenever the FIFO is not empty
// (0 when empty). A push into a full FIFO is accepted when a pop
// happens in the same cycle.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, wdata     - write request and data
//   pop             - read request (ignored while empty)
//   rdata           - head-of-FIFO data
//   full, empty     - occupancy flags
//   count           - occupancy, 0..DEPTH
//   push_ok, pop_ok - the push/pop that actually takes effect this cycle
module sync_fifo_fwft
  import uart_pkg::*;
#(
  parameter int DEPTH  = RXBUF_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok,
  output logic                     pop_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // When full, wr_ptr == rd_ptr: the pop reads the old head before the
  // edge overwrites that slot, so the combined push/pop is safe.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: captures bytes from the UART receiver, acknowledges
// each one on rx_ready_clr and queues it in a FWFT FIFO presented as a
// valid/ready stream. Bytes arriving while the FIFO is full (and not
// popping) are dropped but still acknowledged; overflow is sticky.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   rx_ready, rx_data       - receiver byte-available flag and byte
//   rx_ready_clr            - registered acknowledge to the receiver
//   m_data, m_valid, m_ready- consumer stream
//   count, full, empty      - FIFO occupancy
//   overflow, overflow_clr  - sticky drop flag and its clear (set wins)
// Optional (macro UART_RX_BUF_STATS_EN):
//   rx_byte_cnt [15:0]      - acknowledged bytes, wrapping
//   drop_cnt    [7:0]       - dropped bytes, saturating at 255
//
// Capture FSM:
//   state | meaning
//   WAIT  | idle; rx_ready=1 pushes rx_data and moves to ACK
//   ACK   | rx_ready_clr high until rx_ready is sampled low
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH  = RXBUF_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ready,
  input  logic [DATA_W-1:0]      rx_data,
  output logic                   rx_ready_clr,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   overflow_clr
`ifdef UART_RX_BUF_STATS_EN
  ,
  output logic [15:0]            rx_byte_cnt,
  output logic [7:0]             drop_cnt
`endif
);

  rxbuf_state_t state;
  logic         capture;
  logic         drop;
  logic         push_ok;
  logic         pop_ok;

  // rx_ready is only looked at in WAIT, so a held flag yields one push.
  assign capture = (state == WAIT) && rx_ready;
  assign drop    = capture && !push_ok;
  assign m_valid = !empty;

  sync_fifo_fwft #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (capture),
    .wdata   (rx_data),
    .pop     (m_ready),
    .rdata   (m_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAIT;
      rx_ready_clr <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;

      case (state)
        WAIT: begin
          if (rx_ready) begin
            state        <= ACK;
            rx_ready_clr <= 1'b1;
          end
        end
        ACK: begin
          if (!rx_ready) begin
            state        <= WAIT;
            rx_ready_clr <= 1'b0;
          end
        end
        default: begin
          state        <= WAIT;
          rx_ready_clr <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_BUF_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (capture) rx_byte_cnt <= rx_byte_cnt + 1'b1;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready_clr;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [4:0]        count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              overflow_clr;
`ifdef UART_RX_BUF_STATS_EN
  logic [15:0]       rx_byte_cnt;
  logic [7:0]        drop_cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q [$];

  uart_rx_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef UART_RX_BUF_STATS_EN
    ,
    .rx_byte_cnt  (rx_byte_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One receiver byte: rx_ready raised at a negedge, captured at the next
  // posedge, held one extra cycle in ACK, then dropped.
  task automatic send_byte(input logic [7:0] b, input bit exp_push,
                           input bit pop_now, input bit clr_now);
    logic [7:0] h;
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    overflow_clr = clr_now;
    if (pop_now) begin
      m_ready = 1'b1;
      if (exp_q.size() == 0) check("pop_model_empty", 32'd0, 32'd1);
      else begin
        h = exp_q.pop_front();
        check("pop_head_at_capture", m_data, h);
      end
    end
    if (exp_push) exp_q.push_back(b);
    @(posedge clk); #1;
    m_ready = 1'b0;
    overflow_clr = 1'b0;
    check("clr_rise", rx_ready_clr, 1);
    @(negedge clk);
    check("clr_hold", rx_ready_clr, 1);
    rx_ready = 1'b0;
    @(posedge clk); #1;
    check("clr_fall", rx_ready_clr, 0);
  endtask

  task automatic pop_byte();
    logic [7:0] h;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("drain_model_empty", 32'd0, 32'd1);
    end else begin
      h = exp_q.pop_front();
      check("drain_valid", m_valid, 1);
      check("drain_data", m_data, h);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rx_ready = 1'b0;
    rx_data = '0;
    m_ready = 1'b0;
    overflow_clr = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clr", rx_ready_clr, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // single byte 0xA5: visible one cycle after capture
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    check("a5_valid", m_valid, 1);
    check("a5_data", m_data, 8'hA5);
    check("a5_count", count, 1);
    check("a5_clr", rx_ready_clr, 1);
    rx_data = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    check("a5_clr_held", rx_ready_clr, 1);
    check("a5_no_repush", count, 1);
    @(negedge clk);
    rx_ready = 1'b0;
    @(posedge clk); #1;
    check("a5_clr_fall", rx_ready_clr, 0);
    pop_byte();
    @(negedge clk);
    check("a5_empty", empty, 1);

    // fill to 16, 17th dropped
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_ovf_clear", overflow, 0);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    check("drop_ovf", overflow, 1);
    check("drop_count", count, 16);
    check("drop_head", m_data, 8'h00);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    check("ovf_clr_alone", overflow, 0);
    for (int i = 0; i < 16; i++) pop_byte();
    check("drain_empty", empty, 1);
    check("drain_valid_low", m_valid, 0);
    check("drain_data_zero", m_data, 0);
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("mready_empty_count", count, 0);

    // drop and clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    send_byte(8'hDD, 1'b0, 1'b0, 1'b1);
    check("set_wins_ovf", overflow, 1);
    check("set_wins_count", count, 16);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    check("later_clr", overflow, 0);

    // full FIFO, 17th byte with simultaneous pop: accepted
    send_byte(8'hEE, 1'b1, 1'b1, 1'b0);
    check("pushpop_count", count, 16);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_head", m_data, 8'h11);
    for (int i = 0; i < 16; i++) pop_byte();
    check("pushpop_empty", empty, 1);

    // reset while in ACK with 5 bytes buffered
    for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = 8'h77;
    @(posedge clk); #1;
    check("ack_count5", count, 5);
    check("ack_clr", rx_ready_clr, 1);
    #2 rst = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_clr", rx_ready_clr, 0);
    check("async_valid", m_valid, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h77);
    @(posedge clk); #1;
    check("recap_count", count, 1);
    check("recap_clr", rx_ready_clr, 1);
    check("recap_data", m_data, 8'h77);
    @(negedge clk);
    rx_ready = 1'b0;
    @(posedge clk); #1;
    check("recap_clr_fall", rx_ready_clr, 0);
    pop_byte();
    check("recap_empty", empty, 1);

`ifdef UART_RX_BUF_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("stats_rst_bytes", rx_byte_cnt, 0);
    check("stats_rst_drops", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'h80 + 8'(i), (i < 16), 1'b0, 1'b0);
    check("stats_bytes", rx_byte_cnt, 20);
    check("stats_drops", drop_cnt, 4);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    check("stats_bytes_after_clr", rx_byte_cnt, 20);
    check("stats_drops_after_clr", drop_cnt, 4);
    for (int i = 0; i < 16; i++) pop_byte();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each byte flagged by the receiver's `ready`, acknowledges it via `ready_clr`, and stores it in a first-word-fall-through FIFO. Bytes are presented to the consumer (command parser / display logic) on a valid/ready stream. Overflow is detected and flagged sticky.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DATA_W`, 8: byte width; must match receiver `data_out`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_ready` in 1: receiver byte-available flag; held high until cleared.
- `rx_data` in `DATA_W`: receiver byte; stable while `rx_ready`=1.
- `rx_ready_clr` out 1: acknowledge to the receiver's `ready_clr`.
- `m_data` out `DATA_W`: head-of-FIFO byte.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: consumer accepts the byte.
- `count` out `$clog2(DEPTH)+1`: current occupancy.
- `full` out 1: `count`==`DEPTH`.
- `empty` out 1: `count`==0.
- `overflow` out 1: sticky; a byte was dropped.
- `overflow_clr` in 1: clears `overflow`.

## Operation
- Capture FSM states:
  - `WAIT`: on sampled `rx_ready`=1, try a push of `rx_data`, then go to `ACK`.
  - `ACK`: `rx_ready_clr`=1; stay until `rx_ready` is sampled 0, then return to `WAIT`.
- Push succeeds if `!full`, or if `full` and a pop occurs in the same cycle.
- Otherwise the byte is dropped, `overflow` is set, and FIFO contents are unchanged.
- Every received byte is acknowledged, including dropped bytes, so the receiver never stalls.
- Pop happens when `m_valid && m_ready`. `m_valid` = `!empty`. `m_data` = `mem[rd_ptr]` when `!empty`, else 0.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` goes +1 on push-only, −1 on pop-only, and is unchanged on simultaneous push and pop.
- `overflow_clr` clears `overflow`. If a drop occurs in the same cycle, set wins.

## Timing
- Reset values: `rx_ready_clr`=0, `m_valid`=0, `m_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0. FSM is in `WAIT`. Memory contents are don't-care.
- Latency:
  - Edge N samples `rx_ready`=1 and performs the push.
  - `m_valid`=1 from cycle N+1 if the FIFO was empty.
  - `rx_ready_clr` is registered, high from cycle N+1.
  - `rx_ready_clr` stays high until the edge that samples `rx_ready`=0, and is low the cycle after.
- Minimum of 3 cycles per captured byte. A UART byte period far exceeds this.
- `rx_ready` is never re-sampled in `ACK`, so one receiver byte gives exactly one push.
- Reset mid-operation:
  - FIFO empties, FSM returns to `WAIT`, `rx_ready_clr` drops asynchronously.
  - If the receiver still holds `rx_ready`=1 after reset release, that byte is captured again. This is intended behaviour.
- `m_ready` may be held high continuously. It has no effect while `empty`.
- Full at 16 and a new byte with no pop: byte dropped, `count` stays 16, head unchanged.

## Configuration
- `UART_RX_BUF_STATS_EN` defined adds two output ports:
  - `rx_byte_cnt` [15:0]: counts every acknowledged byte.
  - `drop_cnt` [7:0]: counts dropped bytes, saturating at 255.
  - Both reset to 0 and are unaffected by `overflow_clr`.
  - `rx_byte_cnt` wraps at 65535→0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8.
  - Enum `rxbuf_state_t` {`WAIT`, `ACK`}.
  - `DEPTH` default constant.
- One sub-module `sync_fifo_fwft`:
  - Parameterised `DEPTH`/`DATA_W`; push/pop/full/empty/count.
  - Push-when-full-with-pop supported.
  - `uart_rx_buffer` holds the capture FSM, overflow flag and stats.

## Test plan
- Reset, then receiver presents 0xA5 → `m_valid`=1 with `m_data`=0xA5 one cycle after capture. `rx_ready_clr` pulses until `rx_ready` falls. `count`=1.
- 16 bytes 0x00..0x0F with `m_ready`=0 → `full`=1, `count`=16. A 17th byte 0xFF is dropped and acknowledged, `overflow`=1. Draining yields 0x00..0x0F in order, then `empty`=1.
- Full FIFO, 17th byte arriving in the same cycle as a pop → no drop, `count` stays 16. The last byte popped is the 17th byte.
- `overflow_clr` asserted in the same cycle as a drop → `overflow` remains 1. A later clear alone → 0.
- `rst` asserted while in `ACK` with 5 bytes buffered → immediately `count`=0, `rx_ready_clr`=0, `m_valid`=0. After release with `rx_ready` still 1, that byte is re-captured, `count`=1.
- With `UART_RX_BUF_STATS_EN`: 20 bytes, 4 dropped → `rx_byte_cnt`=20, `drop_cnt`=4.
